// File: rtl/riscv_imem.sv
// riscv_imem: word-organised instruction memory with a boot-time image loader.
// A host streams the program image in after reset; fetches return NOP until the
// load completes, then return one stored word per cycle with a one-cycle latency.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_LOAD | accepting image words at sequential slots, fetches answer NOP
// S_RUN  | image complete, loader ignored, fetches served from memory
module riscv_imem #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter int unsigned          DEPTH     = 256,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h00000013,
  localparam int unsigned         ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WORD_SIZE-1:0] fetch_addr_i,
  output logic [WORD_SIZE-1:0] fetch_instr_o,
  output logic                 fetch_valid_o,
  output logic                 fetch_misalign_o,
  output logic                 fetch_fault_o,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [WORD_SIZE-1:0] load_data_i,
  input  logic                 load_last_i,
  output logic [ADDR_W:0]      load_count_o,
  output logic                 boot_done_o,
  output logic                 load_err_o
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // One past the highest legal byte address; one bit wider so the compare
  // cannot wrap when DEPTH*4 fills the whole address space.
  localparam logic [WORD_SIZE:0] FETCH_LIMIT = (WORD_SIZE+1)'(64'(DEPTH) * 64'd4);
  localparam logic [ADDR_W-1:0]  LAST_SLOT   = ADDR_W'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   load_err_q, load_err_d;
  logic [ADDR_W-1:0]      wr_ptr;
  logic                   load_accept;
  logic                   at_last_slot;

  logic [WORD_SIZE-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]      fetch_idx;
  logic                   fetch_misaligned;
  logic                   fetch_out_of_range;

  logic [WORD_SIZE-1:0]   fetch_instr_q, fetch_instr_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   fetch_misalign_q, fetch_misalign_d;
  logic                   fetch_fault_q, fetch_fault_d;

  // The write pointer is the low bits of the word count; the extra count bit
  // only ever sets when the last slot has been written, at which point we are
  // in RUN and the pointer is no longer used.
  assign wr_ptr       = count_q[ADDR_W-1:0];
  assign load_ready_o = (state_q == S_LOAD);
  assign load_accept  = load_valid_i && load_ready_o;
  assign at_last_slot = (wr_ptr == LAST_SLOT);

  // Loader controller: next state, word count and sticky overflow error.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load_err_d = load_err_q;
    if (load_accept) begin
      count_d = count_q + 1'b1;
      if (load_last_i || at_last_slot) begin
        state_d = S_RUN;
      end
      if (at_last_slot && !load_last_i) begin
        load_err_d = 1'b1;
      end
    end
  end

  // Loader controller registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LOAD;
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // Instruction storage; not reset, contents are only reachable from RUN.
  always_ff @(posedge clk_i) begin
    if (load_accept) begin
      mem_q[wr_ptr] <= load_data_i;
    end
  end

  // Address bits above the word index only take part in the range check.
  assign fetch_idx          = fetch_addr_i[ADDR_W+1:2];
  assign fetch_misaligned   = (fetch_addr_i[1:0] != 2'b00);
  assign fetch_out_of_range = ({1'b0, fetch_addr_i} >= FETCH_LIMIT);

  // Fetch response: misalignment beats range fault, and memory is only read
  // once the controller is already in RUN before this edge.
  always_comb begin
    fetch_instr_d    = NOP_INSTR;
    fetch_valid_d    = 1'b0;
    fetch_misalign_d = 1'b0;
    fetch_fault_d    = 1'b0;
    if (fetch_misaligned) begin
      fetch_misalign_d = 1'b1;
    end else if (fetch_out_of_range) begin
      fetch_fault_d = 1'b1;
    end else if (state_q == S_RUN) begin
      fetch_instr_d = mem_q[fetch_idx];
      fetch_valid_d = 1'b1;
    end
  end

  // Fetch response registers, one cycle after the address is sampled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_instr_q    <= NOP_INSTR;
      fetch_valid_q    <= 1'b0;
      fetch_misalign_q <= 1'b0;
      fetch_fault_q    <= 1'b0;
    end else begin
      fetch_instr_q    <= fetch_instr_d;
      fetch_valid_q    <= fetch_valid_d;
      fetch_misalign_q <= fetch_misalign_d;
      fetch_fault_q    <= fetch_fault_d;
    end
  end

  assign fetch_instr_o    = fetch_instr_q;
  assign fetch_valid_o    = fetch_valid_q;
  assign fetch_misalign_o = fetch_misalign_q;
  assign fetch_fault_o    = fetch_fault_q;
  assign load_count_o     = count_q;
  assign boot_done_o      = (state_q == S_RUN);
  assign load_err_o       = load_err_q;

endmodule
